trv_mem_arbiter: RTL and testbench



---
 rtl/rtcore_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/trv_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_trv_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtcore_pkg.sv
// Shared ray-traversal core definitions: default build widths, tag sizing
// helper and outstanding-request default used by the memory arbiters.
`ifndef NUM_TRV
`define NUM_TRV 4
`endif
`ifndef BBOX_MEM_REQ_WIDTH
`define BBOX_MEM_REQ_WIDTH 32
`endif
`ifndef BBOX_MEM_RESP_WIDTH
`define BBOX_MEM_RESP_WIDTH 32
`endif

package rtcore_pkg;

   localparam int unsigned MAX_OUTSTANDING_DEFAULT = 4;

   // Tag width needed to name n ports; never narrower than one bit.
   function automatic int unsigned calc_tag_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   typedef logic [calc_tag_w(`NUM_TRV)-1:0] trv_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// after ptr, wrapping modulo N.
module rr_arbiter
   import rtcore_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = calc_tag_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any_gnt
);

   // Scan from the pointer position and take the first active request.
   always_comb begin
      logic [IW-1:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IW'((32'(ptr) + k) % N);
         if (!any_gnt && req[idx]) begin
            any_gnt      = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/trv_mem_arbiter.sv
// Shares one memory port among several traversal-unit request/response
// stream pairs: round-robin request arbitration with source tagging,
// tag-routed responses and per-port outstanding-request credits.
module trv_mem_arbiter
   import rtcore_pkg::*;
#(
   parameter int unsigned NUM_PORTS       = `NUM_TRV,
   parameter int unsigned REQ_WIDTH       = `BBOX_MEM_REQ_WIDTH,
   parameter int unsigned RESP_WIDTH      = `BBOX_MEM_RESP_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
   localparam int unsigned TAG_W          = calc_tag_w(NUM_PORTS),
   localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  req_empty_n [0:NUM_PORTS-1],
   output logic                  req_read    [0:NUM_PORTS-1],
   input  logic [REQ_WIDTH-1:0]  req_dout    [0:NUM_PORTS-1],
   input  logic                  resp_full_n [0:NUM_PORTS-1],
   output logic                  resp_write  [0:NUM_PORTS-1],
   output logic [RESP_WIDTH-1:0] resp_din    [0:NUM_PORTS-1],
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [REQ_WIDTH-1:0]  mem_req_data,
   output logic [TAG_W-1:0]      mem_req_tag,
   input  logic                  mem_resp_valid,
   output logic                  mem_resp_ready,
   input  logic [RESP_WIDTH-1:0] mem_resp_data,
   input  logic [TAG_W-1:0]      mem_resp_tag,
   output logic                  err_bad_resp
);

   logic [NUM_PORTS-1:0] elig;
   logic [NUM_PORTS-1:0] gnt;
   logic [TAG_W-1:0]     gnt_idx;
   logic [TAG_W-1:0]     rr_ptr;
   logic                 any_gnt;
   logic                 reg_free;
   logic                 grant_fire;
   logic [CNT_W-1:0]     cnt [0:NUM_PORTS-1];
   logic [NUM_PORTS-1:0] resp_hit;
   logic                 resp_legal;
   logic                 resp_sel_full_n;

   // A port competes only when it has a request and spare credit.
   always_comb begin
      elig = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         elig[p] = req_empty_n[p] && (cnt[p] < CNT_W'(MAX_OUTSTANDING));
      end
   end

   rr_arbiter #(
      .N  (NUM_PORTS),
      .IW (TAG_W)
   ) u_rr_arbiter (
      .req     (elig),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   assign reg_free   = !mem_req_valid || mem_req_ready;
   assign grant_fire = arst_n && reg_free && any_gnt;

   // Pop the granted request stream in the cycle it is loaded.
   always_comb begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         req_read[p] = grant_fire && gnt[p];
      end
   end

   // Decode the response tag; tags beyond NUM_PORTS never match, so they
   // fall out as illegal together with tags that have no credit in use.
   always_comb begin
      resp_hit        = '0;
      resp_legal      = 1'b0;
      resp_sel_full_n = 1'b0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (mem_resp_tag == TAG_W'(p) && cnt[p] != '0) begin
            resp_hit[p]     = 1'b1;
            resp_legal      = 1'b1;
            resp_sel_full_n = resp_full_n[p];
         end
      end
   end

   // Route a legal response to its port; illegal ones are consumed and dropped.
   always_comb begin
      mem_resp_ready = 1'b0;
      if (arst_n) begin
         mem_resp_ready = resp_legal ? resp_sel_full_n : 1'b1;
      end
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         resp_write[p] = arst_n && resp_hit[p] && mem_resp_valid && resp_full_n[p];
         resp_din[p]   = mem_resp_data;
      end
   end

   // Output register and round-robin pointer advance on each grant.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         mem_req_valid <= 1'b0;
         mem_req_data  <= '0;
         mem_req_tag   <= '0;
         rr_ptr        <= '0;
      end else if (reg_free) begin
         mem_req_valid <= any_gnt;
         if (any_gnt) begin
            mem_req_data <= req_dout[gnt_idx];
            mem_req_tag  <= gnt_idx;
            rr_ptr       <= (gnt_idx == TAG_W'(NUM_PORTS - 1)) ? '0
                                                                : gnt_idx + TAG_W'(1);
         end
      end
   end

   // Per-port in-flight counters; grant and delivered response cancel out.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            cnt[p] <= '0;
         end
      end else begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            case ({req_read[p], resp_write[p]})
               2'b10:   cnt[p] <= cnt[p] + CNT_W'(1);
               2'b01:   cnt[p] <= cnt[p] - CNT_W'(1);
               default: cnt[p] <= cnt[p];
            endcase
         end
      end
   end

   // Sticky flag for any response that arrives without a matching request.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         err_bad_resp <= 1'b0;
      end else if (mem_resp_valid && !resp_legal) begin
         err_bad_resp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_trv_mem_arbiter.sv
// Directed bench for trv_mem_arbiter with four ports and four credits each.
module tb_trv_mem_arbiter;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       req_empty_n [0:3];
   logic       req_read    [0:3];
   logic [7:0] req_dout    [0:3];
   logic       resp_full_n [0:3];
   logic       resp_write  [0:3];
   logic [7:0] resp_din    [0:3];
   logic       mem_req_valid;
   logic       mem_req_ready;
   logic [7:0] mem_req_data;
   logic [1:0] mem_req_tag;
   logic       mem_resp_valid;
   logic       mem_resp_ready;
   logic [7:0] mem_resp_data;
   logic [1:0] mem_resp_tag;
   logic       err_bad_resp;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   trv_mem_arbiter #(
      .NUM_PORTS       (4),
      .REQ_WIDTH       (8),
      .RESP_WIDTH      (8),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk            (clk),
      .arst_n         (arst_n),
      .req_empty_n    (req_empty_n),
      .req_read       (req_read),
      .req_dout       (req_dout),
      .resp_full_n    (resp_full_n),
      .resp_write     (resp_write),
      .resp_din       (resp_din),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_data   (mem_req_data),
      .mem_req_tag    (mem_req_tag),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_ready (mem_resp_ready),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_tag   (mem_resp_tag),
      .err_bad_resp   (err_bad_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] rd_vec();
      logic [3:0] v;
      for (int p = 0; p < 4; p++) v[p] = req_read[p];
      return v;
   endfunction

   function automatic logic [3:0] wr_vec();
      logic [3:0] v;
      for (int p = 0; p < 4; p++) v[p] = resp_write[p];
      return v;
   endfunction

   task automatic set_empty(input logic [3:0] v);
      for (int p = 0; p < 4; p++) req_empty_n[p] = v[p];
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      set_empty(4'b0000);
      for (int p = 0; p < 4; p++) begin
         req_dout[p]    = 8'h00;
         resp_full_n[p] = 1'b1;
      end
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 8'h00;
      mem_resp_tag   = 2'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      arst_n = 1'b0;
      tick();
      tick();
      arst_n = 1'b1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      set_empty(4'b1111);
      mem_resp_valid = 1'b1;
      mem_resp_tag   = 2'd0;
      #1;
      n_cmp++; if (rd_vec() !== 4'b0000) begin n_bad++; $display("FAIL reset_req_read: got %b want 0000", rd_vec()); end
      n_cmp++; if (mem_resp_ready !== 1'b0) begin n_bad++; $display("FAIL reset_resp_ready: got %b want 0", mem_resp_ready); end
      n_cmp++; if (wr_vec() !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_write: got %b want 0000", wr_vec()); end
      tick();
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", mem_req_valid); end
      n_cmp++; if (mem_req_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", mem_req_data); end
      n_cmp++; if (mem_req_tag !== 2'd0) begin n_bad++; $display("FAIL reset_tag: got %0d want 0", mem_req_tag); end
      n_cmp++; if (err_bad_resp !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_bad_resp); end
      do_reset();
   endtask

   task automatic test_single_port();
      do_reset();
      set_empty(4'b0100);
      req_dout[2] = 8'hA5;
      #1;
      n_cmp++; if (rd_vec() !== 4'b0100) begin n_bad++; $display("FAIL single_read: got %b want 0100", rd_vec()); end
      tick();
      set_empty(4'b1001);
      req_dout[0] = 8'h0C;
      req_dout[3] = 8'h3C;
      #1;
      n_cmp++; if (mem_req_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", mem_req_valid); end
      n_cmp++; if (mem_req_tag !== 2'd2) begin n_bad++; $display("FAIL single_tag: got %0d want 2", mem_req_tag); end
      n_cmp++; if (mem_req_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %h want a5", mem_req_data); end
      n_cmp++; if (rd_vec() !== 4'b1000) begin n_bad++; $display("FAIL single_ptr3: got %b want 1000", rd_vec()); end
      tick();
      set_empty(4'b0001);
      #1;
      n_cmp++; if (mem_req_tag !== 2'd3 || mem_req_data !== 8'h3C) begin n_bad++; $display("FAIL single_tag3: got %0d/%h want 3/3c", mem_req_tag, mem_req_data); end
      n_cmp++; if (rd_vec() !== 4'b0001) begin n_bad++; $display("FAIL single_wrap: got %b want 0001", rd_vec()); end
      tick();
      set_empty(4'b0000);
      #1;
      n_cmp++; if (mem_req_tag !== 2'd0 || mem_req_data !== 8'h0C) begin n_bad++; $display("FAIL single_tag0: got %0d/%h want 0/0c", mem_req_tag, mem_req_data); end
      n_cmp++; if (rd_vec() !== 4'b0000) begin n_bad++; $display("FAIL single_noread: got %b want 0000", rd_vec()); end
      tick();
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_fall: got %b want 0", mem_req_valid); end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_rd;
      logic [3:0] exp_wr;
      do_reset();
      set_empty(4'b1111);
      for (int p = 0; p < 4; p++) req_dout[p] = 8'h10 + 8'(p);
      for (int i = 0; i < 12; i++) begin
         exp_rd = 4'b0001 << (i % 4);
         if (i > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 2'((i - 1) % 4);
            mem_resp_data  = 8'h80 + 8'(i);
         end
         #1;
         n_cmp++; if (rd_vec() !== exp_rd) begin n_bad++; $display("FAIL fair_read[%0d]: got %b want %b", i, rd_vec(), exp_rd); end
         if (i > 0) begin
            exp_wr = 4'b0001 << ((i - 1) % 4);
            n_cmp++; if (mem_req_tag !== 2'((i - 1) % 4)) begin n_bad++; $display("FAIL fair_tag[%0d]: got %0d want %0d", i, mem_req_tag, (i - 1) % 4); end
            n_cmp++; if (mem_req_data !== 8'h10 + 8'((i - 1) % 4)) begin n_bad++; $display("FAIL fair_data[%0d]: got %h", i, mem_req_data); end
            n_cmp++; if (wr_vec() !== exp_wr || mem_resp_ready !== 1'b1) begin n_bad++; $display("FAIL fair_resp[%0d]: got %b/%b want %b/1", i, wr_vec(), mem_resp_ready, exp_wr); end
         end
         tick();
      end
      mem_resp_valid = 1'b0;
   endtask

   task automatic test_credit();
      do_reset();
      set_empty(4'b0001);
      req_dout[0] = 8'h44;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_cmp++; if (rd_vec() !== 4'b0001) begin n_bad++; $display("FAIL credit_read[%0d]: got %b want 0001", c, rd_vec()); end
         tick();
      end
      #1;
      n_cmp++; if (rd_vec() !== 4'b0000) begin n_bad++; $display("FAIL credit_block: got %b want 0000", rd_vec()); end
      tick();
      #1;
      n_cmp++; if (rd_vec() !== 4'b0000 || mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL credit_idle: got %b/%b want 0000/0", rd_vec(), mem_req_valid); end
      tick();
      mem_resp_valid = 1'b1;
      mem_resp_tag   = 2'd0;
      mem_resp_data  = 8'h99;
      #1;
      n_cmp++; if (mem_resp_ready !== 1'b1 || wr_vec() !== 4'b0001) begin n_bad++; $display("FAIL credit_resp: got %b/%b want 1/0001", mem_resp_ready, wr_vec()); end
      n_cmp++; if (resp_din[0] !== 8'h99) begin n_bad++; $display("FAIL credit_din: got %h want 99", resp_din[0]); end
      n_cmp++; if (rd_vec() !== 4'b0000) begin n_bad++; $display("FAIL credit_same_cycle: got %b want 0000", rd_vec()); end
      tick();
      mem_resp_valid = 1'b0;
      #1;
      n_cmp++; if (rd_vec() !== 4'b0001) begin n_bad++; $display("FAIL credit_fifth: got %b want 0001", rd_vec()); end
      tick();
      #1;
      n_cmp++; if (rd_vec() !== 4'b0000) begin n_bad++; $display("FAIL credit_reblock: got %b want 0000", rd_vec()); end
   endtask

   task automatic test_stall();
      do_reset();
      set_empty(4'b0111);
      for (int p = 0; p < 4; p++) req_dout[p] = 8'h30 + 8'(p);
      #1;
      n_cmp++; if (rd_vec() !== 4'b0001) begin n_bad++; $display("FAIL stall_first: got %b want 0001", rd_vec()); end
      tick();
      mem_req_ready = 1'b0;
      req_dout[0]   = 8'hFF;
      for (int s = 0; s < 5; s++) begin
         #1;
         n_cmp++; if (rd_vec() !== 4'b0000) begin n_bad++; $display("FAIL stall_read[%0d]: got %b want 0000", s, rd_vec()); end
         n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_tag !== 2'd0 || mem_req_data !== 8'h30) begin n_bad++; $display("FAIL stall_hold[%0d]: got %b/%0d/%h want 1/0/30", s, mem_req_valid, mem_req_tag, mem_req_data); end
         tick();
      end
      mem_req_ready = 1'b1;
      #1;
      n_cmp++; if (rd_vec() !== 4'b0010) begin n_bad++; $display("FAIL stall_resume1: got %b want 0010", rd_vec()); end
      tick();
      #1;
      n_cmp++; if (mem_req_tag !== 2'd1 || mem_req_data !== 8'h31) begin n_bad++; $display("FAIL stall_tag1: got %0d/%h want 1/31", mem_req_tag, mem_req_data); end
      n_cmp++; if (rd_vec() !== 4'b0100) begin n_bad++; $display("FAIL stall_resume2: got %b want 0100", rd_vec()); end
      tick();
      #1;
      n_cmp++; if (mem_req_tag !== 2'd2 || mem_req_data !== 8'h32) begin n_bad++; $display("FAIL stall_tag2: got %0d/%h want 2/32", mem_req_tag, mem_req_data); end
      n_cmp++; if (rd_vec() !== 4'b0001) begin n_bad++; $display("FAIL stall_resume0: got %b want 0001", rd_vec()); end
   endtask

   task automatic test_backpressure();
      do_reset();
      set_empty(4'b0010);
      req_dout[1] = 8'h51;
      #1;
      n_cmp++; if (rd_vec() !== 4'b0010) begin n_bad++; $display("FAIL bp_grant: got %b want 0010", rd_vec()); end
      tick();
      set_empty(4'b0000);
      mem_resp_valid = 1'b1;
      mem_resp_tag   = 2'd1;
      mem_resp_data  = 8'hE1;
      resp_full_n[1] = 1'b0;
      #1;
      n_cmp++; if (mem_resp_ready !== 1'b0 || wr_vec() !== 4'b0000) begin n_bad++; $display("FAIL bp_full: got %b/%b want 0/0000", mem_resp_ready, wr_vec()); end
      tick();
      resp_full_n[1] = 1'b1;
      set_empty(4'b0010);
      #1;
      n_cmp++; if (mem_resp_ready !== 1'b1 || wr_vec() !== 4'b0010) begin n_bad++; $display("FAIL bp_release: got %b/%b want 1/0010", mem_resp_ready, wr_vec()); end
      n_cmp++; if (resp_din[1] !== 8'hE1) begin n_bad++; $display("FAIL bp_din: got %h want e1", resp_din[1]); end
      n_cmp++; if (rd_vec() !== 4'b0010) begin n_bad++; $display("FAIL bp_collide_grant: got %b want 0010", rd_vec()); end
      tick();
      set_empty(4'b0000);
      mem_resp_data = 8'hE2;
      #1;
      n_cmp++; if (wr_vec() !== 4'b0010) begin n_bad++; $display("FAIL bp_cnt_kept: got %b want 0010", wr_vec()); end
      tick();
      #1;
      n_cmp++; if (err_bad_resp !== 1'b0) begin n_bad++; $display("FAIL bp_err_clear: got %b want 0", err_bad_resp); end
      n_cmp++; if (mem_resp_ready !== 1'b1 || wr_vec() !== 4'b0000) begin n_bad++; $display("FAIL bp_cnt_drained: got %b/%b want 1/0000", mem_resp_ready, wr_vec()); end
      tick();
      mem_resp_valid = 1'b0;
      n_cmp++; if (err_bad_resp !== 1'b1) begin n_bad++; $display("FAIL bp_err_set: got %b want 1", err_bad_resp); end
   endtask

   task automatic test_illegal();
      do_reset();
      mem_resp_valid = 1'b1;
      mem_resp_tag   = 2'd3;
      #1;
      n_cmp++; if (mem_resp_ready !== 1'b1 || wr_vec() !== 4'b0000) begin n_bad++; $display("FAIL illegal_drop: got %b/%b want 1/0000", mem_resp_ready, wr_vec()); end
      tick();
      mem_resp_valid = 1'b0;
      n_cmp++; if (err_bad_resp !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", err_bad_resp); end
      tick();
      tick();
      tick();
      n_cmp++; if (err_bad_resp !== 1'b1) begin n_bad++; $display("FAIL illegal_sticky: got %b want 1", err_bad_resp); end
      do_reset();
      n_cmp++; if (err_bad_resp !== 1'b0) begin n_bad++; $display("FAIL illegal_reset_clears: got %b want 0", err_bad_resp); end
      set_empty(4'b0100);
      req_dout[2] = 8'h22;
      #1;
      n_cmp++; if (rd_vec() !== 4'b0100) begin n_bad++; $display("FAIL midflight_grant: got %b want 0100", rd_vec()); end
      tick();
      do_reset();
      n_cmp++; if (mem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midflight_valid: got %b want 0", mem_req_valid); end
      mem_resp_valid = 1'b1;
      mem_resp_tag   = 2'd2;
      #1;
      n_cmp++; if (mem_resp_ready !== 1'b1 || wr_vec() !== 4'b0000) begin n_bad++; $display("FAIL midflight_drop: got %b/%b want 1/0000", mem_resp_ready, wr_vec()); end
      tick();
      mem_resp_valid = 1'b0;
      n_cmp++; if (err_bad_resp !== 1'b1) begin n_bad++; $display("FAIL midflight_err: got %b want 1", err_bad_resp); end
      do_reset();
   endtask

   initial begin
      arst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      test_reset();
      test_single_port();
      test_fairness();
      test_credit();
      test_stall();
      test_backpressure();
      test_illegal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
